// File: rtl/sync_fifo_mod.sv
// rtl/sync_fifo_mod.sv - single-clock register-array FIFO with occupancy, threshold and sticky error flags
module sync_fifo_mod #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 5,
  parameter int AFULL_TH  = 28,
  parameter int AEMPTY_TH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wrdata,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rddata,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   data_cnt,
  output logic              overflow,
  output logic              underflow,
  input  logic              clr_err
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0]   DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   AFULL_C  = (ADDR_W+1)'(AFULL_TH);
  localparam logic [ADDR_W:0]   AEMPTY_C = (ADDR_W+1)'(AEMPTY_TH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              wr_acc;
  logic              rd_acc;

  assign full         = (data_cnt == DEPTH_C);
  assign empty        = (data_cnt == '0);
  assign almost_full  = (data_cnt >= AFULL_C);
  assign almost_empty = (data_cnt <= AEMPTY_C);

  // Acceptance uses pre-edge flags: no fall-through when empty, no replace when full.
  assign wr_acc = wr_en & ~full;
  assign rd_acc = rd_en & ~empty;

  always_ff @(posedge clk) begin
    if (!rst && wr_acc) begin
      mem[wr_ptr] <= wrdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      data_cnt <= '0;
      rddata   <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rddata <= mem[rd_ptr];
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({wr_acc, rd_acc})
        2'b10:   data_cnt <= data_cnt + CNT_ONE;
        2'b01:   data_cnt <= data_cnt - CNT_ONE;
        default: data_cnt <= data_cnt;
      endcase
    end
  end

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_err) begin
        overflow <= 1'b0;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end else if (clr_err) begin
        underflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo_mod.sv
// tb/tb_sync_fifo_mod.sv - directed table and sequence checks for sync_fifo_mod
`timescale 1ns/1ps
module tb_sync_fifo_mod;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] wrdata;
  logic       rd_en;
  logic [7:0] rddata;
  logic       rd_valid;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic [5:0] data_cnt;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic       wr_en;
    logic [7:0] wrdata;
    logic       rd_en;
    logic       clr_err;
    int         cnt;
    logic       rv;
    logic [7:0] rddata;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       udf;
  } vec_t;

  vec_t vec [10];

  sync_fifo_mod dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wrdata       (wrdata),
    .rd_en        (rd_en),
    .rddata       (rddata),
    .rd_valid     (rd_valid),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .data_cnt     (data_cnt),
    .overflow     (overflow),
    .underflow    (underflow),
    .clr_err      (clr_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change 1ns after the edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wrdata = '0; rd_en = 1'b0; clr_err = 1'b0;

    //                wr  data   rd clr  cnt rv rddata full empty ovf udf
    vec[0] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[1] = '{1'b1, 8'h11, 1'b1, 1'b0, 1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vec[2] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[3] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 0, 1'b0, 8'h11, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[5] = '{1'b1, 8'h22, 1'b0, 1'b0, 1, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[6] = '{1'b1, 8'h33, 1'b1, 1'b0, 1, 1'b1, 8'h22, 1'b0, 1'b0, 1'b0, 1'b0};
    vec[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0};
    vec[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 8'h33, 1'b0, 1'b1, 1'b0, 1'b0};

    #1;
    do_reset();
    chk("rst_cnt", data_cnt, 0);
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_rv", rd_valid, 0);
    chk("rst_rddata", rddata, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);

    // Underflow, empty wr+rd, clr_err precedence
    for (int i = 0; i < 10; i++) begin
      wr_en = vec[i].wr_en; wrdata = vec[i].wrdata;
      rd_en = vec[i].rd_en; clr_err = vec[i].clr_err;
      step();
      chk($sformatf("vec%0d_cnt", i), data_cnt, vec[i].cnt);
      chk($sformatf("vec%0d_rv", i), rd_valid, vec[i].rv);
      chk($sformatf("vec%0d_rddata", i), rddata, vec[i].rddata);
      chk($sformatf("vec%0d_full", i), full, vec[i].full);
      chk($sformatf("vec%0d_empty", i), empty, vec[i].empty);
      chk($sformatf("vec%0d_ovf", i), overflow, vec[i].ovf);
      chk($sformatf("vec%0d_udf", i), underflow, vec[i].udf);
    end
    wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;

    // 31 writes, thresholds crossed on the way up
    do_reset();
    for (int i = 1; i <= 31; i++) begin
      wr_en = 1'b1; wrdata = 8'(i);
      step();
      chk("t1_cnt", data_cnt, i);
      if (i == 4)  chk("t1_ae_at4", almost_empty, 1);
      if (i == 5)  chk("t1_ae_at5", almost_empty, 0);
      if (i == 27) chk("t1_af_at27", almost_full, 0);
      if (i == 28) chk("t1_af_at28", almost_full, 1);
    end
    wr_en = 1'b0;
    chk("t1_full", full, 0);
    chk("t1_empty", empty, 0);
    chk("t1_afull", almost_full, 1);

    // 15 back-to-back reads
    for (int i = 1; i <= 15; i++) begin
      rd_en = 1'b1;
      step();
      chk("t2_rv", rd_valid, 1);
      chk("t2_rddata", rddata, i);
    end
    rd_en = 1'b0;
    step();
    chk("t2_rv_drop", rd_valid, 0);
    chk("t2_rddata_hold", rddata, 15);
    chk("t2_cnt", data_cnt, 16);

    // Fill to full, overflow, read on full, drain
    do_reset();
    for (int i = 0; i < 32; i++) begin
      wr_en = 1'b1; wrdata = 8'(8'h40 + i);
      step();
    end
    chk("t3_full", full, 1);
    chk("t3_cnt32", data_cnt, 32);
    chk("t3_ovf_pre", overflow, 0);
    wrdata = 8'hAA;
    step();
    chk("t3_ovf", overflow, 1);
    chk("t3_full_hold", full, 1);
    chk("t3_cnt_hold", data_cnt, 32);
    wrdata = 8'hBB; rd_en = 1'b1;
    step();
    chk("t3_rdfull_rv", rd_valid, 1);
    chk("t3_rdfull_data", rddata, 8'h40);
    chk("t3_rdfull_cnt", data_cnt, 31);
    wr_en = 1'b0;
    for (int i = 1; i < 32; i++) begin
      step();
      chk("t3_drain", rddata, 8'h40 + i);
    end
    rd_en = 1'b0;
    step();
    chk("t3_empty", empty, 1);
    chk("t3_cnt0", data_cnt, 0);
    chk("t3_ovf_sticky", overflow, 1);
    chk("t3_udf", underflow, 0);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("t3_ovf_clr", overflow, 0);

    // Steady wr+rd at count 10 across pointer wrap
    do_reset();
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wrdata = 8'(i);
      step();
    end
    rd_en = 1'b1;
    for (int k = 0; k < 50; k++) begin
      wrdata = 8'(k + 10);
      step();
      chk("t5_cnt", data_cnt, 10);
      chk("t5_rv", rd_valid, 1);
      chk("t5_rddata", rddata, k);
    end
    rd_en = 1'b0;

    // Reset mid read burst at count 20
    for (int i = 60; i < 72; i++) begin
      wr_en = 1'b1; wrdata = 8'(i);
      step();
    end
    wr_en = 1'b0;
    chk("t6_cnt22", data_cnt, 22);
    rd_en = 1'b1;
    step();
    chk("t6_burst0", rddata, 50);
    step();
    chk("t6_burst1", rddata, 51);
    chk("t6_cnt20", data_cnt, 20);
    rst = 1'b1;
    step();
    chk("t6_cnt", data_cnt, 0);
    chk("t6_empty", empty, 1);
    chk("t6_rv", rd_valid, 0);
    chk("t6_rddata", rddata, 0);
    chk("t6_ovf", overflow, 0);
    chk("t6_udf", underflow, 0);
    rst = 1'b0; rd_en = 1'b0;
    wr_en = 1'b1; wrdata = 8'h55;
    step();
    wr_en = 1'b0; rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("t6_after_rv", rd_valid, 1);
    chk("t6_after_data", rddata, 8'h55);
    chk("t6_after_cnt", data_cnt, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
